// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions of the NZCV flags inside the status word.
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef logic [3:0] reg_idx_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW detection: compares the ID sources against the EXE and MEM
// destinations. With forwarding, only a load in EXE can still cause a stall.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  reg_idx_t id_src1,
  input  reg_idx_t id_src2,
  input  logic     id_two_src,
  input  logic     id_src1_en,
  input  reg_idx_t exe_dest,
  input  logic     exe_wb_en,
  input  logic     exe_mem_r_en,
  input  reg_idx_t mem_dest,
  input  logic     mem_wb_en,
  output logic     raw_hazard
);

  reg_idx_t   src_idx [2];
  logic [1:0] src_en;
  logic [1:0] exe_match;
  logic [1:0] mem_match;

  assign src_idx[0] = id_src1;
  assign src_idx[1] = id_src2;
  assign src_en     = {id_two_src, id_src1_en};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign exe_match[gi] = src_en[gi] && exe_wb_en && (exe_dest == src_idx[gi]);
      assign mem_match[gi] = src_en[gi] && mem_wb_en && (mem_dest == src_idx[gi]);
    end
  endgenerate

  assign raw_hazard = FWD_EN ? ((|exe_match) && exe_mem_r_en)
                             : ((|exe_match) || (|mem_match));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline freeze/flush sequencing, memory-wait FSM, NZCV status register and
// saturating stall counters for the five-stage core.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 4,
  parameter bit FWD_EN   = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_idx_t         id_src1,
  input  reg_idx_t         id_src2,
  input  logic             id_two_src,
  input  logic             id_src1_en,
  input  reg_idx_t         exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  reg_idx_t         mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_mem_r_en,
  input  logic             mem_mem_w_en,
  input  logic             branch_taken,
  input  logic             exe_s,
  input  logic [3:0]       alu_status,
  output logic             freeze_all,
  output logic             hazard,
  output logic             freeze_if,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic [3:0]       status,
  output logic [CNT_W-1:0] hazard_cycles,
  output logic [CNT_W-1:0] mem_wait_cycles
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [3:0]       status_reg;
  logic [CNT_W-1:0] hazard_cnt_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             raw_hazard;
  logic             mem_is_mem;

  hazard_detect #(
    .FWD_EN(FWD_EN)
  ) u_hazard_detect (
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_src1_en  (id_src1_en),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .raw_hazard  (raw_hazard)
  );

  assign mem_is_mem = mem_mem_r_en | mem_mem_w_en;

  // DONE always returns to RUN so a serviced access gets one advance cycle
  // and is not picked up again while it is still sitting in MEM.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    freeze_all = 1'b0;
    case (state_reg)
      RUN: begin
        if (mem_is_mem && (MEM_WAIT > 0)) begin
          freeze_all = 1'b1;
          if (MEM_WAIT == 1) begin
            state_next = DONE;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(MEM_WAIT - 1);
          end
        end
      end
      WAIT: begin
        freeze_all = 1'b1;
        cnt_next   = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Freeze outranks branch, which outranks the RAW stall.
  assign hazard       = raw_hazard & ~branch_taken & ~freeze_all;
  assign freeze_if    = hazard;
  assign flush_if_id  = branch_taken & ~freeze_all;
  assign flush_id_exe = (branch_taken | hazard) & ~freeze_all;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= RUN;
      cnt_reg        <= '0;
      status_reg     <= '0;
      hazard_cnt_reg <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (exe_s && !freeze_all) begin
        status_reg <= alu_status;
      end
      if (hazard && !(&hazard_cnt_reg)) begin
        hazard_cnt_reg <= hazard_cnt_reg + CNT_W'(1);
      end
      if (freeze_all && !(&wait_cnt_reg)) begin
        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign status = {status_reg[N_BIT], status_reg[Z_BIT], status_reg[C_BIT], status_reg[V_BIT]};
  assign hazard_cycles   = hazard_cnt_reg;
  assign mem_wait_cycles = wait_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one forwarding instance and one
// non-forwarding instance share the same stimulus.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest, alu_status;
  logic        id_two_src, id_src1_en, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic        mem_mem_r_en, mem_mem_w_en, branch_taken, exe_s;

  logic        f_freeze_all, f_hazard, f_freeze_if, f_flush_if_id, f_flush_id_exe;
  logic [3:0]  f_status;
  logic [15:0] f_hazard_cycles, f_mem_wait_cycles;
  logic        n_freeze_all, n_hazard, n_freeze_if, n_flush_if_id, n_flush_id_exe;
  logic [3:0]  n_status;
  logic [15:0] n_hazard_cycles, n_mem_wait_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_WAIT(4), .FWD_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_src1_en(id_src1_en),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_mem_r_en(mem_mem_r_en), .mem_mem_w_en(mem_mem_w_en),
    .branch_taken(branch_taken), .exe_s(exe_s), .alu_status(alu_status),
    .freeze_all(f_freeze_all), .hazard(f_hazard), .freeze_if(f_freeze_if),
    .flush_if_id(f_flush_if_id), .flush_id_exe(f_flush_id_exe), .status(f_status),
    .hazard_cycles(f_hazard_cycles), .mem_wait_cycles(f_mem_wait_cycles)
  );

  pipeline_ctrl #(.MEM_WAIT(4), .FWD_EN(1'b0), .CNT_W(16)) dut_nf (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_src1_en(id_src1_en),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_mem_r_en(mem_mem_r_en), .mem_mem_w_en(mem_mem_w_en),
    .branch_taken(branch_taken), .exe_s(exe_s), .alu_status(alu_status),
    .freeze_all(n_freeze_all), .hazard(n_hazard), .freeze_if(n_freeze_if),
    .flush_if_id(n_flush_if_id), .flush_id_exe(n_flush_id_exe), .status(n_status),
    .hazard_cycles(n_hazard_cycles), .mem_wait_cycles(n_mem_wait_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("t=%0t check %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  // Move to just after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0; alu_status = 4'd0;
    id_two_src = 1'b0; id_src1_en = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_wb_en = 1'b0; mem_mem_r_en = 1'b0; mem_mem_w_en = 1'b0;
    branch_taken = 1'b0; exe_s = 1'b0;

    next_cycle();
    next_cycle();
    chk("reset_freeze_all", 32'(f_freeze_all), 32'd0);
    chk("reset_status", 32'(f_status), 32'd0);
    chk("reset_hazard_cycles", 32'(f_hazard_cycles), 32'd0);
    chk("reset_mem_wait_cycles", 32'(f_mem_wait_cycles), 32'd0);
    #2 rst = 1'b1;

    // Load-use: load in EXE writes r3, ID reads r3.
    next_cycle();
    exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    id_src1 = 4'd3; id_src1_en = 1'b1;
    #4;
    chk("loaduse_hazard", 32'(f_hazard), 32'd1);
    chk("loaduse_freeze_if", 32'(f_freeze_if), 32'd1);
    chk("loaduse_flush_id_exe", 32'(f_flush_id_exe), 32'd1);
    chk("loaduse_flush_if_id", 32'(f_flush_if_id), 32'd0);
    next_cycle();
    chk("loaduse_hazard_cycles", 32'(f_hazard_cycles), 32'd1);
    exe_mem_r_en = 1'b0;
    #4;
    chk("alu_dep_fwd_hazard", 32'(f_hazard), 32'd0);
    chk("alu_dep_nofwd_hazard", 32'(n_hazard), 32'd1);
    next_cycle();
    chk("hazard_cycles_hold", 32'(f_hazard_cycles), 32'd1);
    exe_wb_en = 1'b0; id_src1_en = 1'b0;

    // Second source against MEM, no forwarding.
    id_src2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1; id_two_src = 1'b1;
    #4;
    chk("src2_nofwd_hazard", 32'(n_hazard), 32'd1);
    chk("src2_fwd_hazard", 32'(f_hazard), 32'd0);
    next_cycle();
    id_two_src = 1'b0;
    #4;
    chk("src2_gated_hazard", 32'(n_hazard), 32'd0);
    next_cycle();
    mem_wb_en = 1'b0;

    // Status update, then hold.
    exe_s = 1'b1; alu_status = 4'b1010;
    next_cycle();
    chk("status_update", 32'(f_status), 32'b1010);
    exe_s = 1'b0; alu_status = 4'b0101;
    next_cycle();
    chk("status_hold", 32'(f_status), 32'b1010);

    // Memory wait with a branch arriving during WAIT.
    mem_mem_r_en = 1'b1;
    #4;
    chk("memwait_c1_freeze", 32'(f_freeze_all), 32'd1);
    next_cycle();
    branch_taken = 1'b1; exe_s = 1'b1; alu_status = 4'b1111;
    #4;
    chk("memwait_c2_freeze", 32'(f_freeze_all), 32'd1);
    chk("frozen_flush_if_id", 32'(f_flush_if_id), 32'd0);
    chk("frozen_flush_id_exe", 32'(f_flush_id_exe), 32'd0);
    next_cycle();
    #4;
    chk("memwait_c3_freeze", 32'(f_freeze_all), 32'd1);
    chk("frozen_status", 32'(f_status), 32'b1010);
    next_cycle();
    #4;
    chk("memwait_c4_freeze", 32'(f_freeze_all), 32'd1);
    next_cycle();
    #4;
    chk("done_freeze", 32'(f_freeze_all), 32'd0);
    chk("done_flush_if_id", 32'(f_flush_if_id), 32'd1);
    chk("done_flush_id_exe", 32'(f_flush_id_exe), 32'd1);
    next_cycle();
    chk("mem_wait_cycles", 32'(f_mem_wait_cycles), 32'd4);
    chk("status_after_done", 32'(f_status), 32'b1111);
    branch_taken = 1'b0; exe_s = 1'b0;
    #4;
    chk("backtoback_freeze", 32'(f_freeze_all), 32'd1);
    next_cycle();
    next_cycle();

    // Now in WAIT with cnt=2: reset asynchronously.
    mem_mem_r_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mid_freeze", 32'(f_freeze_all), 32'd0);
    chk("rst_mid_status", 32'(f_status), 32'd0);
    chk("rst_mid_hazard_cycles", 32'(f_hazard_cycles), 32'd0);
    chk("rst_mid_mem_wait_cycles", 32'(f_mem_wait_cycles), 32'd0);
    #2 rst = 1'b1;
    next_cycle();
    #4;
    chk("post_rst_freeze", 32'(f_freeze_all), 32'd0);
    mem_mem_w_en = 1'b1;
    #1;
    chk("post_rst_store_freeze", 32'(f_freeze_all), 32'd1);
    next_cycle();
    mem_mem_w_en = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
